// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between two producers, the FIFO write side and the debug counters.
// The arbiter takes the slave side. The producers, the FIFO and the bench take the master side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
);
  logic          REQ0;
  logic [DW-1:0] DIN0;
  logic          ACK0;
  logic          REQ1;
  logic [DW-1:0] DIN1;
  logic          ACK1;
  logic          FULL;
  logic          WR;
  logic [DW-1:0] DOUT;
  logic [1:0]    GNT;
  logic [CW-1:0] CNT0;
  logic [CW-1:0] CNT1;
  logic [CW-1:0] STALL;

  modport master (
    output REQ0, DIN0, REQ1, DIN1, FULL,
    input  ACK0, ACK1, WR, DOUT, GNT, CNT0, CNT1, STALL
  );

  modport slave (
    input  REQ0, DIN0, REQ1, DIN1, FULL,
    output ACK0, ACK1, WR, DOUT, GNT, CNT0, CNT1, STALL
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for two producers that share one FIFO write port.
// It issues at most one write every two cycles, so FULL from the previous write is seen before the next grant.
module fifo_wr_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input logic              CLK,
  input logic              RST,
  fifo_wr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [CW-1:0] stall_q, stall_d;
  logic          grant0, grant1;

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    dout_d  = dout_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    stall_d = stall_q;
    // last_q=1 means requester 1 won last, so requester 0 wins a tie.
    grant0  = bus.REQ0 && (!bus.REQ1 || last_q);
    grant1  = bus.REQ1 && (!bus.REQ0 || !last_q);
    case (state_q)
      IDLE: begin
        if (bus.FULL) begin
          if (bus.REQ0 || bus.REQ1) stall_d = stall_q + CW'(1);
        end else if (grant0) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          ack0_d  = 1'b1;
          dout_d  = bus.DIN0;
          last_d  = 1'b0;
          cnt0_d  = cnt0_q + CW'(1);
        end else if (grant1) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          ack1_d  = 1'b1;
          dout_d  = bus.DIN1;
          last_d  = 1'b1;
          cnt1_d  = cnt1_q + CW'(1);
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      dout_q  <= '0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      stall_q <= stall_d;
    end
  end

  assign bus.WR    = wr_q;
  assign bus.ACK0  = ack0_q;
  assign bus.ACK1  = ack1_q;
  assign bus.GNT   = {ack1_q, ack0_q};
  assign bus.DOUT  = dout_q;
  assign bus.CNT0  = cnt0_q;
  assign bus.CNT1  = cnt1_q;
  assign bus.STALL = stall_q;
endmodule
